// File: rtl/core_ctrl_pkg.sv
// Shared definitions for the core run controller: FSM state encoding,
// button indices and LED slice selector codes.
package core_ctrl_pkg;

    typedef enum logic [1:0] {
        RST_HOLD = 2'd0,
        HALT     = 2'd1,
        RUN      = 2'd2,
        STEP     = 2'd3
    } run_state_t;

    localparam int NUM_BTNS = 4;
    localparam int BTN_RST  = 0;
    localparam int BTN_RUN  = 1;
    localparam int BTN_STEP = 2;
    localparam int BTN_SEL  = 3;

    localparam logic [2:0] LED_SEL_A_LO = 3'd0;
    localparam logic [2:0] LED_SEL_A_HI = 3'd1;
    localparam logic [2:0] LED_SEL_B_LO = 3'd2;
    localparam logic [2:0] LED_SEL_B_HI = 3'd3;
    localparam logic [2:0] LED_SEL_C_LO = 3'd4;
    localparam logic [2:0] LED_SEL_C_HI = 3'd5;
    localparam logic [2:0] LED_SEL_D_LO = 3'd6;
    localparam logic [2:0] LED_SEL_D_HI = 3'd7;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, counting debouncer and a
// one-cycle press pulse on the debounced rising edge (releases are silent).
module btn_debounce #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_raw,
    output logic press
);

    logic        sync1_reg;
    logic        sync2_reg;
    logic        stable_reg;
    logic        stable_next;
    logic        stable_d_reg;
    logic        press_reg;
    logic [15:0] count_reg;
    logic [15:0] count_next;

    // Any cycle where the synchronized input agrees with the stable value
    // restarts the run of disagreeing cycles.
    always_comb begin
        count_next  = '0;
        stable_next = stable_reg;
        if (sync2_reg != stable_reg) begin
            if (count_reg >= DEBOUNCE_CYCLES - 16'd1) begin
                stable_next = ~stable_reg;
            end else begin
                count_next = count_reg + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_reg    <= 1'b0;
            sync2_reg    <= 1'b0;
            stable_reg   <= 1'b0;
            stable_d_reg <= 1'b0;
            count_reg    <= '0;
            press_reg    <= 1'b0;
        end else begin
            sync1_reg    <= btn_raw;
            sync2_reg    <= sync1_reg;
            stable_reg   <= stable_next;
            stable_d_reg <= stable_reg;
            count_reg    <= count_next;
            press_reg    <= stable_reg & ~stable_d_reg;
        end
    end

    assign press = press_reg;

endmodule

// File: rtl/core_run_ctrl.sv
// Run/halt/single-step controller for a soft core, with LED port viewer.
// Optional enabled-cycle counter built when CORE_CYCLE_COUNTER_EN is defined.
module core_run_ctrl
    import core_ctrl_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter logic [7:0]  RESET_CYCLES    = 8'd16,
    parameter int          WIDTH           = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             btn_rst,
    input  logic             btn_run,
    input  logic             btn_step,
    input  logic             btn_sel,
    input  logic [WIDTH-1:0] port_a,
    input  logic [WIDTH-1:0] port_b,
    input  logic [WIDTH-1:0] port_c,
    input  logic [WIDTH-1:0] port_d,
    output logic             core_reset,
    output logic             core_ce,
    output logic [15:0]      led,
    output logic [1:0]       run_state,
    output logic [31:0]      cycle_count
);

    logic [NUM_BTNS-1:0] btn_raw;
    logic [NUM_BTNS-1:0] press;

    assign btn_raw = {btn_sel, btn_step, btn_run, btn_rst};

    generate
        for (genvar gi = 0; gi < NUM_BTNS; gi++) begin : g_btn
            btn_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_btn_debounce (
                .clk    (clk),
                .reset_n(reset_n),
                .btn_raw(btn_raw[gi]),
                .press  (press[gi])
            );
        end
    endgenerate

    run_state_t state_reg;
    run_state_t state_next;
    logic [7:0] hold_reg;
    logic [7:0] hold_next;
    logic       core_reset_reg;
    logic       core_ce_reg;
    logic [2:0] led_sel_reg;
    logic [15:0] led_reg;

    // Press priority rst > run > step; losing presses are simply dropped.
    always_comb begin
        state_next = state_reg;
        hold_next  = '0;
        if (press[BTN_RST]) begin
            state_next = RST_HOLD;
        end else begin
            case (state_reg)
                RST_HOLD: begin
                    if (hold_reg == RESET_CYCLES) begin
                        state_next = HALT;
                    end else begin
                        hold_next = hold_reg + 8'd1;
                    end
                end
                HALT: begin
                    if (press[BTN_RUN]) begin
                        state_next = RUN;
                    end else if (press[BTN_STEP]) begin
                        state_next = STEP;
                    end
                end
                RUN: begin
                    if (press[BTN_RUN]) begin
                        state_next = HALT;
                    end
                end
                default: state_next = HALT;
            endcase
        end
    end

    // Outputs are registered from the next state so they line up with run_state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= RST_HOLD;
            hold_reg       <= '0;
            core_reset_reg <= 1'b1;
            core_ce_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            hold_reg       <= hold_next;
            core_reset_reg <= (state_next == RST_HOLD);
            core_ce_reg    <= (state_next != HALT);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            led_sel_reg <= LED_SEL_A_LO;
            led_reg     <= '0;
        end else begin
            if (press[BTN_SEL]) begin
                led_sel_reg <= led_sel_reg + 3'd1;
            end
            case (led_sel_reg)
                LED_SEL_A_LO: led_reg <= port_a[15:0];
                LED_SEL_A_HI: led_reg <= port_a[31:16];
                LED_SEL_B_LO: led_reg <= port_b[15:0];
                LED_SEL_B_HI: led_reg <= port_b[31:16];
                LED_SEL_C_LO: led_reg <= port_c[15:0];
                LED_SEL_C_HI: led_reg <= port_c[31:16];
                LED_SEL_D_LO: led_reg <= port_d[15:0];
                default:      led_reg <= port_d[31:16];
            endcase
        end
    end

`ifdef CORE_CYCLE_COUNTER_EN
    logic [31:0] cycle_count_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cycle_count_reg <= '0;
        end else if (state_next == RST_HOLD) begin
            cycle_count_reg <= '0;
        end else if (core_ce_reg && !core_reset_reg) begin
            cycle_count_reg <= cycle_count_reg + 32'd1;
        end
    end

    assign cycle_count = cycle_count_reg;
`else
    assign cycle_count = '0;
`endif

    assign core_reset = core_reset_reg;
    assign core_ce    = core_ce_reg;
    assign led        = led_reg;
    assign run_state  = state_reg;

endmodule

// File: tb/tb_core_run_ctrl.sv
// Self-checking bench for core_run_ctrl with a cycle-level reference model
// built from button sample histories and the controller's behavioural rules.
module tb_core_run_ctrl;

    localparam int DB = 4;
    localparam int RC = 3;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  btn = '0;   // {sel, step, run, rst}
    logic [31:0] port_a = '0, port_b = '0, port_c = '0, port_d = '0;
    logic        core_reset, core_ce;
    logic [15:0] led;
    logic [1:0]  run_state;
    logic [31:0] cycle_count;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    core_run_ctrl #(
        .DEBOUNCE_CYCLES(16'(DB)),
        .RESET_CYCLES   (8'(RC)),
        .WIDTH          (32)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .btn_rst    (btn[0]),
        .btn_run    (btn[1]),
        .btn_step   (btn[2]),
        .btn_sel    (btn[3]),
        .port_a     (port_a),
        .port_b     (port_b),
        .port_c     (port_c),
        .port_d     (port_d),
        .core_reset (core_reset),
        .core_ce    (core_ce),
        .led        (led),
        .run_state  (run_state),
        .cycle_count(cycle_count)
    );

    // Reference model. State numbers: 0 reset-hold, 1 halt, 2 run, 3 step.
    bit          hist [4][DB+2];   // raw samples, index DB+1 is the newest
    bit   [3:0]  m_stable, m_rise, m_press;
    int          m_state, m_held;
    bit          m_rst_o, m_ce_o;
    logic [2:0]  m_sel;
    logic [15:0] m_led;
    logic [31:0] m_cc;

    function automatic logic [15:0] slice_of(logic [2:0] s);
        logic [31:0] w;
        case (s[2:1])
            2'd0:    w = port_a;
            2'd1:    w = port_b;
            2'd2:    w = port_c;
            default: w = port_d;
        endcase
        return s[0] ? w[31:16] : w[15:0];
    endfunction

    task automatic model_reset();
        for (int b = 0; b < 4; b++)
            for (int j = 0; j < DB + 2; j++) hist[b][j] = 1'b0;
        m_stable = '0; m_rise = '0; m_press = '0;
        m_state = 0; m_held = 0;
        m_rst_o = 1'b1; m_ce_o = 1'b0;
        m_sel = '0; m_led = '0; m_cc = '0;
    endtask

    task automatic model_edge();
        bit [3:0] p = m_press;
        int       nxt = m_state;
        // A debounced value flips once the last DB synchronized samples
        // (two cycles old and older) all disagree with it.
        for (int b = 0; b < 4; b++) begin
            bit all_differ = 1'b1;
            for (int j = 1; j <= DB; j++)
                if (hist[b][j] == m_stable[b]) all_differ = 1'b0;
            m_press[b] = m_rise[b];
            m_rise[b]  = all_differ && !m_stable[b];
            if (all_differ) m_stable[b] = ~m_stable[b];
            for (int j = 0; j < DB + 1; j++) hist[b][j] = hist[b][j+1];
            hist[b][DB+1] = btn[b];
        end
        if (p[0]) begin
            nxt = 0; m_held = 0;
        end else if (m_state == 0) begin
            if (m_held == RC) nxt = 1; else m_held++;
        end else if (m_state == 1) begin
            if (p[1]) nxt = 2; else if (p[2]) nxt = 3;
        end else if (m_state == 2) begin
            if (p[1]) nxt = 1;
        end else begin
            nxt = 1;
        end
`ifdef CORE_CYCLE_COUNTER_EN
        if (nxt == 0) m_cc = '0;
        else if (m_ce_o && !m_rst_o) m_cc = m_cc + 32'd1;
`else
        m_cc = '0;
`endif
        m_led = slice_of(m_sel);
        if (p[3]) m_sel = m_sel + 3'd1;
        m_state = nxt;
        m_rst_o = (nxt == 0);
        m_ce_o  = (nxt != 1);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic hold_btn(int b, int hi, int lo);
        btn[b] = 1'b1;
        repeat (hi) tick();
        btn[b] = 1'b0;
        repeat (lo) tick();
    endtask

    task automatic test_reset();
        vectors++;
        if (core_reset !== 1'b1 || core_ce !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: core_reset=%b core_ce=%b, required 1 0", core_reset, core_ce);
        end
        vectors++;
        if (run_state !== 2'd0 || led !== 16'h0 || cycle_count !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_state: run_state=%0d led=%h cc=%0d, required 0 0000 0", run_state, led, cycle_count);
        end
        reset_n = 1'b1;
        for (int i = 0; i < RC; i++) begin
            tick();
            vectors++;
            if (core_reset !== 1'b1 || core_ce !== 1'b1 || run_state !== 2'd0) begin
                miscompares++;
                $display("FAIL reset_hold[%0d]: rst=%b ce=%b state=%0d, required 1 1 0", i, core_reset, core_ce, run_state);
            end
        end
        tick();
        vectors++;
        if (core_reset !== 1'b0 || core_ce !== 1'b0 || run_state !== 2'd1) begin
            miscompares++;
            $display("FAIL reset_to_halt: rst=%b ce=%b state=%0d, required 0 0 1", core_reset, core_ce, run_state);
        end
    endtask

    task automatic test_step();
        int ce_seen = 0;
        btn[2] = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (i == 10) btn[2] = 1'b0;
            tick();
            if (core_ce === 1'b1) ce_seen++;
            vectors++;
            if (run_state !== 2'(m_state) || core_ce !== m_ce_o) begin
                miscompares++;
                $display("FAIL step_cycle[%0d]: state=%0d ce=%b, required %0d %b", i, run_state, core_ce, m_state, m_ce_o);
            end
        end
        vectors++;
        if (ce_seen != 1 || run_state !== 2'd1) begin
            miscompares++;
            $display("FAIL step_once: ce cycles=%0d state=%0d, required 1 1", ce_seen, run_state);
        end
        vectors++;
`ifdef CORE_CYCLE_COUNTER_EN
        if (cycle_count !== 32'd1) begin
`else
        if (cycle_count !== 32'd0) begin
`endif
            miscompares++;
            $display("FAIL step_count: cycle_count=%0d, required %0d", cycle_count, m_cc);
        end
    endtask

    task automatic test_run();
        hold_btn(1, 2, 12);
        vectors++;
        if (run_state !== 2'd1 || core_ce !== 1'b0) begin
            miscompares++;
            $display("FAIL run_bounce: state=%0d ce=%b, required 1 0", run_state, core_ce);
        end
        hold_btn(1, 10, 2);
        for (int i = 0; i < 8; i++) begin
            tick();
            vectors++;
            if (run_state !== 2'd2 || core_ce !== 1'b1) begin
                miscompares++;
                $display("FAIL run_active[%0d]: state=%0d ce=%b, required 2 1", i, run_state, core_ce);
            end
        end
        hold_btn(1, 10, 10);
        vectors++;
        if (run_state !== 2'd1 || core_ce !== 1'b0) begin
            miscompares++;
            $display("FAIL run_stop: state=%0d ce=%b, required 1 0", run_state, core_ce);
        end
    endtask

    task automatic test_rst_beats_run();
        bit saw_hold = 1'b0;
        hold_btn(1, 10, 10);
        vectors++;
        if (run_state !== 2'd2) begin
            miscompares++;
            $display("FAIL rst_run_setup: state=%0d, required 2", run_state);
        end
        btn[0] = 1'b1; btn[1] = 1'b1;
        for (int i = 0; i < 25; i++) begin
            if (i == 10) btn[1:0] = 2'b00;
            tick();
            if (run_state === 2'd0 && core_reset === 1'b1) saw_hold = 1'b1;
        end
        vectors++;
        if (!saw_hold || run_state !== 2'd1 || cycle_count !== 32'd0) begin
            miscompares++;
            $display("FAIL rst_over_run: saw_hold=%b state=%0d cc=%0d, required 1 1 0", saw_hold, run_state, cycle_count);
        end
    endtask

    task automatic test_led();
        port_a = 32'h1234_5678; port_b = 32'h0BAD_F00D;
        port_c = 32'hDEAD_BEEF; port_d = 32'hCAFE_0001;
        repeat (5) hold_btn(3, 8, 8);
        vectors++;
        if (led !== 16'hDEAD) begin
            miscompares++;
            $display("FAIL led_sel5: led=%h, required dead", led);
        end
        repeat (3) hold_btn(3, 8, 8);
        vectors++;
        if (led !== 16'h5678) begin
            miscompares++;
            $display("FAIL led_wrap: led=%h, required 5678", led);
        end
    endtask

    task automatic test_random();
        int dur [4];
        for (int b = 0; b < 4; b++) dur[b] = 1;
        for (int i = 0; i < 1500; i++) begin
            for (int b = 0; b < 4; b++) begin
                dur[b]--;
                if (dur[b] <= 0) begin
                    btn[b] = ~btn[b];
                    if (b == 0 && btn[b] == 1'b0) dur[b] = int'($urandom_range(40, 200));
                    else dur[b] = int'($urandom_range(1, 12));
                end
            end
            if ($urandom_range(0, 15) == 0) begin
                port_a = $urandom; port_b = $urandom; port_c = $urandom; port_d = $urandom;
            end
            tick();
            vectors++;
            if (run_state !== 2'(m_state) || core_reset !== m_rst_o || core_ce !== m_ce_o) begin
                miscompares++;
                $display("FAIL rand_ctrl[%0d]: state=%0d rst=%b ce=%b, required %0d %b %b",
                         i, run_state, core_reset, core_ce, m_state, m_rst_o, m_ce_o);
            end
            vectors++;
            if (led !== m_led || cycle_count !== m_cc) begin
                miscompares++;
                $display("FAIL rand_data[%0d]: led=%h cc=%0d, required %h %0d", i, led, cycle_count, m_led, m_cc);
            end
        end
        btn = '0;
        repeat (12) tick();
    endtask

    task automatic test_async_reset();
        port_a = 32'h0000_A5A5;
        if (run_state !== 2'd2) hold_btn(1, 10, 10);
        vectors++;
        if (run_state !== 2'(m_state) || led !== m_led) begin
            miscompares++;
            $display("FAIL areset_setup: state=%0d led=%h, required %0d %h", run_state, led, m_state, m_led);
        end
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        vectors++;
        if (core_ce !== 1'b0 || core_reset !== 1'b1 || led !== 16'h0 || run_state !== 2'd0) begin
            miscompares++;
            $display("FAIL areset_immediate: ce=%b rst=%b led=%h state=%0d, required 0 1 0000 0",
                     core_ce, core_reset, led, run_state);
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            vectors++;
            if (run_state !== 2'(m_state) || core_ce !== m_ce_o || led !== m_led) begin
                miscompares++;
                $display("FAIL areset_recover[%0d]: state=%0d ce=%b led=%h, required %0d %b %h",
                         i, run_state, core_ce, led, m_state, m_ce_o, m_led);
            end
        end
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        test_reset();
        test_step();
        test_run();
        test_rst_beats_run();
        test_led();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
